mcu_trace_buf: RTL and testbench

Execution trace capture buffer that sits directly downstream of the MCU core. It watches the core's state, PC, instruction register and W_REG, and records one entry per retired instruction when the core enters RWB. Entries go into a circular buffer that the display/readout logic drains in order with a pop handshake. It also flags a HALT retirement and counts records lost to overflow.

---
 rtl/mcu_trace_buf_if.sv | 34 +++
 rtl/mcu_trace_buf.sv | 115 +++++++++++
 tb/tb_mcu_trace_buf.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcu_trace_buf_if.sv
// Trace buffer bus: core observation inputs, readout pop handshake and status.
// Latency: none; this is a signal bundle.
// Backpressure: none; the readout side pops with rd_en and receives rd_valid.
interface mcu_trace_buf_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clear;
  logic [2:0]    core_state;
  logic [7:0]    core_pc;
  logic [15:0]   core_ir;
  logic [7:0]    core_wreg;
  logic          rd_en;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic [7:0]    ovf_cnt;
  logic          halted;

  // Core and readout side.
  modport master (
    output clear, core_state, core_pc, core_ir, core_wreg, rd_en,
    input  rd_data, rd_valid, count, empty, full, ovf_cnt, halted
  );

  // Trace buffer side.
  modport slave (
    input  clear, core_state, core_pc, core_ir, core_wreg, rd_en,
    output rd_data, rd_valid, count, empty, full, ovf_cnt, halted
  );
endinterface

// File: rtl/mcu_trace_buf.sv
// Circular trace buffer: one {pc, ir, wreg} record per core retirement (entry into RWB).
// Latency: a capture shows in count one cycle later; a pop returns data one cycle after rd_en.
// Backpressure: none toward the core; when full, WRAP=0 drops new records and WRAP=1 overwrites the oldest.
module mcu_trace_buf #(
  parameter int         DEPTH    = 16,
  parameter bit         WRAP     = 1'b0,
  parameter logic [2:0] RWB_CODE = 3'b100
) (
  input logic            clk,
  input logic            reset,
  mcu_trace_buf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [2:0]    state_q;
  logic [31:0]   rd_data_q;
  logic          rd_valid_q;
  logic [7:0]    ovf_q;
  logic          halted_q;

  logic        is_full;
  logic        is_empty;
  logic        cap;
  logic        rd_acc;
  logic        wr_acc;
  logic        ovr;
  logic        lost;
  logic        cnt_inc;
  logic        cnt_dec;
  logic [31:0] rec;

  assign is_full  = (count_q == DEPTH_C);
  assign is_empty = (count_q == '0);
  assign rec      = {bus.core_pc, bus.core_ir, bus.core_wreg};

  // Decode this cycle's capture/pop outcome; a full buffer with a pop frees a slot for the capture.
  always_comb begin
    cap     = (bus.core_state == RWB_CODE) && (state_q != RWB_CODE);
    rd_acc  = bus.rd_en && !is_empty;
    wr_acc  = cap && (!is_full || bus.rd_en || WRAP);
    ovr     = cap && is_full && !bus.rd_en && WRAP;
    lost    = cap && is_full && !bus.rd_en;
    cnt_inc = wr_acc && !rd_acc && !ovr;
    cnt_dec = rd_acc && !wr_acc;
  end

  // Record storage; deliberately not reset or cleared.
  always_ff @(posedge clk) begin
    if (wr_acc && !bus.clear) begin
      mem[wr_ptr] <= rec;
    end
  end

  // Pointers, occupancy, readout register and sticky status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      state_q    <= 3'b000;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= '0;
      halted_q   <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      state_q    <= 3'b000;
      rd_valid_q <= 1'b0;
      ovf_q      <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= bus.core_state;
      rd_valid_q <= rd_acc;
      // When full the read and write slots coincide; this samples the old record before the write lands.
      if (rd_acc) begin
        rd_data_q <= mem[rd_ptr];
      end
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      // Overwrite retires the oldest record by stepping the read side along with the write.
      if (rd_acc || ovr) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (cnt_inc) begin
        count_q <= count_q + CW'(1);
      end else if (cnt_dec) begin
        count_q <= count_q - CW'(1);
      end
      if (lost && (ovf_q != 8'hFF)) begin
        ovf_q <= ovf_q + 8'd1;
      end
      // HALT is flagged on any capture, stored or not.
      if (cap && (bus.core_ir[15:12] == 4'h0)) begin
        halted_q <= 1'b1;
      end
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.count    = count_q;
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.ovf_cnt  = ovf_q;
  assign bus.halted   = halted_q;
endmodule

// File: tb/tb_mcu_trace_buf.sv
module tb_mcu_trace_buf;
  localparam int DEPTH = 16;
  localparam logic [2:0] S_IF  = 3'b000;
  localparam logic [2:0] S_ID  = 3'b001;
  localparam logic [2:0] S_FD  = 3'b010;
  localparam logic [2:0] S_EX  = 3'b011;
  localparam logic [2:0] S_RWB = 3'b100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;

  initial forever #5 clk = ~clk;

  mcu_trace_buf_if #(.DEPTH(DEPTH)) if0 ();
  mcu_trace_buf_if #(.DEPTH(DEPTH)) if1 ();

  assign if1.clear      = if0.clear;
  assign if1.core_state = if0.core_state;
  assign if1.core_pc    = if0.core_pc;
  assign if1.core_ir    = if0.core_ir;
  assign if1.core_wreg  = if0.core_wreg;
  assign if1.rd_en      = if0.rd_en;

  mcu_trace_buf #(.DEPTH(DEPTH), .WRAP(1'b0), .RWB_CODE(S_RWB)) dut0 (
    .clk(clk), .reset(reset), .bus(if0)
  );
  mcu_trace_buf #(.DEPTH(DEPTH), .WRAP(1'b1), .RWB_CODE(S_RWB)) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );

  // Reference model: one record queue per buffer policy (0 = drop, 1 = overwrite).
  logic [31:0] mq0[$];
  logic [31:0] mq1[$];
  int          m_ovf[2];
  bit          m_halt[2];
  bit          m_rvld[2];
  logic [31:0] m_rdata[2];
  logic [2:0]  m_prev;

  function automatic int msize(int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  task automatic mpush(input int k, input logic [31:0] v);
    if (k == 0) mq0.push_back(v);
    else        mq1.push_back(v);
  endtask

  task automatic mpop(input int k, output logic [31:0] v);
    if (k == 0) v = mq0.pop_front();
    else        v = mq1.pop_front();
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    for (int k = 0; k < 2; k++) begin
      m_ovf[k]   = 0;
      m_halt[k]  = 1'b0;
      m_rvld[k]  = 1'b0;
      m_rdata[k] = 32'h0;
    end
    m_prev = 3'b000;
  endtask

  task automatic model_step(input logic [2:0] st, input logic [7:0] pc, input logic [15:0] ir,
                            input logic [7:0] w, input logic rd, input logic clr);
    logic        cap;
    logic [31:0] rec;
    logic [31:0] junk;
    bit          full_b;
    cap = (st == S_RWB) && (m_prev != S_RWB);
    rec = {pc, ir, w};
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        if (k == 0) mq0.delete();
        else        mq1.delete();
        m_ovf[k]  = 0;
        m_halt[k] = 1'b0;
        m_rvld[k] = 1'b0;
      end else begin
        full_b    = (msize(k) == DEPTH);
        m_rvld[k] = 1'b0;
        if (rd && msize(k) > 0) begin
          mpop(k, m_rdata[k]);
          m_rvld[k] = 1'b1;
        end
        if (cap) begin
          if (ir[15:12] == 4'h0) m_halt[k] = 1'b1;
          if (!full_b || rd) begin
            mpush(k, rec);
          end else if (k == 1) begin
            mpop(k, junk);
            mpush(k, rec);
          end
          if (full_b && !rd && m_ovf[k] < 255) m_ovf[k]++;
        end
      end
    end
    m_prev = clr ? 3'b000 : st;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int k, input logic [31:0] rdata, input logic rvld,
                           input logic [4:0] cnt, input logic emp, input logic fl,
                           input logic [7:0] ovf, input logic hlt);
    string p;
    p = (k == 0) ? "drop" : "wrap";
    chk({p, ".count"},    32'(cnt),  32'(msize(k)));
    chk({p, ".empty"},    32'(emp),  32'(msize(k) == 0));
    chk({p, ".full"},     32'(fl),   32'(msize(k) == DEPTH));
    chk({p, ".ovf_cnt"},  32'(ovf),  32'(m_ovf[k]));
    chk({p, ".halted"},   32'(hlt),  32'(m_halt[k]));
    chk({p, ".rd_valid"}, 32'(rvld), 32'(m_rvld[k]));
    chk({p, ".rd_data"},  rdata,     m_rdata[k]);
  endtask

  task automatic check_all();
    check_dut(0, if0.rd_data, if0.rd_valid, if0.count, if0.empty, if0.full, if0.ovf_cnt, if0.halted);
    check_dut(1, if1.rd_data, if1.rd_valid, if1.count, if1.empty, if1.full, if1.ovf_cnt, if1.halted);
  endtask

  // One clock: drive after the falling edge, model at the rising edge, compare at the next falling edge.
  task automatic step(input logic [2:0] st, input logic [7:0] pc, input logic [15:0] ir,
                      input logic [7:0] w, input logic rd, input logic clr);
    if0.core_state = st;
    if0.core_pc    = pc;
    if0.core_ir    = ir;
    if0.core_wreg  = w;
    if0.rd_en      = rd;
    if0.clear      = clr;
    @(posedge clk);
    model_step(st, pc, ir, w, rd, clr);
    @(negedge clk);
    check_all();
  endtask

  task automatic retire(input logic [7:0] pc, input logic [15:0] ir, input logic [7:0] w,
                        input logic rd, input logic clr);
    step(S_IF, pc, ir, w, 1'b0, 1'b0);
    step(S_ID, pc, ir, w, 1'b0, 1'b0);
    step(S_FD, pc, ir, w, 1'b0, 1'b0);
    step(S_EX, pc, ir, w, 1'b0, 1'b0);
    step(S_RWB, pc, ir, w, rd, clr);
  endtask

  task automatic pop();
    step(S_IF, 8'h0, 16'h1fff, 8'h0, 1'b1, 1'b0);
  endtask

  task automatic do_clear();
    step(S_IF, 8'h0, 16'h1fff, 8'h0, 1'b0, 1'b1);
  endtask

  // Asynchronous reset raised mid-cycle; outputs must respond before the next rising edge.
  task automatic do_reset();
    #3 reset = 1'b1;
    #1;
    chk("rst.drop.empty",    32'(if0.empty),    32'd1);
    chk("rst.drop.count",    32'(if0.count),    32'd0);
    chk("rst.drop.rd_valid", 32'(if0.rd_valid), 32'd0);
    chk("rst.drop.ovf_cnt",  32'(if0.ovf_cnt),  32'd0);
    chk("rst.drop.halted",   32'(if0.halted),   32'd0);
    chk("rst.drop.full",     32'(if0.full),     32'd0);
    chk("rst.drop.rd_data",  if0.rd_data,       32'd0);
    chk("rst.wrap.empty",    32'(if1.empty),    32'd1);
    chk("rst.wrap.count",    32'(if1.count),    32'd0);
    chk("rst.wrap.halted",   32'(if1.halted),   32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check_all();
  endtask

  initial begin
    if0.core_state = S_IF;
    if0.core_pc    = 8'h0;
    if0.core_ir    = 16'h1fff;
    if0.core_wreg  = 8'h0;
    if0.rd_en      = 1'b0;
    if0.clear      = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Ordering
    retire(8'h00, 16'h1000, 8'h00, 1'b0, 1'b0);
    retire(8'h01, 16'h1011, 8'h01, 1'b0, 1'b0);
    retire(8'h02, 16'h1002, 8'h00, 1'b0, 1'b0);
    pop();
    chk("order.0", if0.rd_data, 32'h00100000);
    pop();
    chk("order.1", if0.rd_data, 32'h01101101);
    pop();
    chk("order.2", if0.rd_data, 32'h02100200);
    chk("order.empty", 32'(if0.empty), 32'd1);

    // Overflow by one under both policies
    for (int i = 0; i <= 16; i++) retire(8'(i), {8'h10, 8'(i)}, 8'h5a, 1'b0, 1'b0);
    chk("ovf.drop.full",  32'(if0.full),    32'd1);
    chk("ovf.drop.ovf",   32'(if0.ovf_cnt), 32'd1);
    chk("ovf.drop.count", 32'(if0.count),   32'd16);
    chk("ovf.wrap.ovf",   32'(if1.ovf_cnt), 32'd1);
    for (int i = 0; i < 16; i++) begin
      pop();
      chk("ovf.drop.pc", 32'(if0.rd_data[31:24]), 32'(i));
      chk("ovf.wrap.pc", 32'(if1.rd_data[31:24]), 32'(i + 1));
    end

    // Full with simultaneous capture and pop
    do_clear();
    for (int i = 0; i < 16; i++) retire(8'(8'h40 + i), 16'h2000, 8'(i), 1'b0, 1'b0);
    retire(8'h50, 16'h2000, 8'hee, 1'b1, 1'b0);
    chk("fullrw.count", 32'(if0.count),    32'd16);
    chk("fullrw.ovf",   32'(if0.ovf_cnt),  32'd0);
    chk("fullrw.data",  if0.rd_data,       32'h40200000);
    chk("fullrw.vld",   32'(if0.rd_valid), 32'd1);

    // Empty with simultaneous capture and pop
    for (int i = 0; i < 16; i++) pop();
    retire(8'h60, 16'h3000, 8'h01, 1'b1, 1'b0);
    chk("emptyrw.vld",   32'(if0.rd_valid), 32'd0);
    chk("emptyrw.count", 32'(if0.count),    32'd1);

    // Clear beats capture
    retire(8'h61, 16'h3000, 8'h02, 1'b0, 1'b1);
    chk("clrcap.count", 32'(if0.count), 32'd0);

    // HALT parked in RWB
    step(S_IF, 8'h20, 16'h0000, 8'h77, 1'b0, 1'b0);
    step(S_ID, 8'h20, 16'h0000, 8'h77, 1'b0, 1'b0);
    step(S_FD, 8'h20, 16'h0000, 8'h77, 1'b0, 1'b0);
    step(S_EX, 8'h20, 16'h0000, 8'h77, 1'b0, 1'b0);
    chk("halt.pre", 32'(if0.halted), 32'd0);
    step(S_RWB, 8'h20, 16'h0000, 8'h77, 1'b0, 1'b0);
    chk("halt.flag",  32'(if0.halted), 32'd1);
    chk("halt.count", 32'(if0.count),  32'd1);
    for (int i = 1; i < 50; i++) step(S_RWB, 8'h20, 16'h0000, 8'h77, 1'b0, 1'b0);
    chk("halt.once", 32'(if0.count), 32'd1);
    pop();
    chk("halt.data",   if0.rd_data,       32'h20000077);
    chk("halt.sticky", 32'(if0.halted),   32'd1);

    // Overflow counter saturation, captures two cycles apart
    do_clear();
    for (int i = 0; i < 300; i++) begin
      step(S_RWB, 8'(i), 16'h4000, 8'(i), 1'b0, 1'b0);
      step(S_IF,  8'(i), 16'h4000, 8'(i), 1'b0, 1'b0);
    end
    chk("sat.drop", 32'(if0.ovf_cnt), 32'd255);
    chk("sat.wrap", 32'(if1.ovf_cnt), 32'd255);

    // Randomized traffic, including back-to-back captures and stray clears
    do_clear();
    for (int i = 0; i < 800; i++) begin
      logic [2:0] st;
      st = ($urandom_range(0, 2) == 0) ? S_RWB : 3'($urandom_range(0, 7));
      step(st, 8'($urandom), 16'($urandom), 8'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 149) == 0));
    end

    // Reset mid-operation
    retire(8'h99, 16'h5000, 8'h11, 1'b0, 1'b0);
    do_reset();
    check_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
